demux_1to4: RTL and testbench

DEMUX_1TO4 -- requirements
Module: demux_1to4

---
 rtl/demux_1to4_pkg.sv | 16 +
 rtl/demux_1to4_if.sv | 17 +
 rtl/demux_1to4_decode.sv | 21 ++
 rtl/demux_1to4.sv | 41 ++++
 tb/tb_demux_1to4.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/demux_1to4_pkg.sv
// Shared constants and types for the 1-to-4 registered demultiplexer.
package demux_1to4_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [NUM_CH-1:0] ch_en_t;

   // Select encodings: the sel value names the channel it addresses.
   localparam sel_t SEL_CH0 = 2'b00;
   localparam sel_t SEL_CH1 = 2'b01;
   localparam sel_t SEL_CH2 = 2'b10;
   localparam sel_t SEL_CH3 = 2'b11;

endpackage : demux_1to4_pkg

// File: rtl/demux_1to4_if.sv
// Bundle of the demux data signals: din/sel going in, four packed channels out.
// There is no handshake. The master drives din and sel every cycle.
// The slave registers them on each rising clk edge and presents dout one cycle later.
interface demux_1to4_if
   import demux_1to4_pkg::*;
#(
   parameter int WIDTH = 1
);

   logic [WIDTH-1:0]        din;
   sel_t                    sel;
   logic [NUM_CH*WIDTH-1:0] dout;

   modport master (output din, output sel, input  dout);
   modport slave  (input  din, input  sel, output dout);

endinterface : demux_1to4_if

// File: rtl/demux_1to4_decode.sv
// Combinational select decoder: turns the 2-bit sel into a one-hot channel enable.
module demux_1to4_decode
   import demux_1to4_pkg::*;
(
   input  sel_t   sel,
   output ch_en_t en
);

   // Exactly one enable bit is set for every sel value.
   always_comb begin
      en = '0;
      case (sel)
         SEL_CH0: en = 4'b0001;
         SEL_CH1: en = 4'b0010;
         SEL_CH2: en = 4'b0100;
         SEL_CH3: en = 4'b1000;
         default: en = '0;
      endcase
   end

endmodule : demux_1to4_decode

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer. The channel addressed by sel loads din.
// The other three channels load zero. All four channels are flops with no
// combinational path from din or sel to dout, so the latency is one cycle.
module demux_1to4
   import demux_1to4_pkg::*;
#(
   parameter int WIDTH = 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH-1:0]        din,
   input  sel_t                    sel,
   output logic [NUM_CH*WIDTH-1:0] dout
);

   ch_en_t                  ch_en;
   logic [NUM_CH*WIDTH-1:0] dout_d;

   demux_1to4_decode u_decode (
      .sel (sel),
      .en  (ch_en)
   );

   // Gate din into each channel slot with that channel's enable bit. Unselected slots become zero.
   always_comb begin
      dout_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         dout_d[i*WIDTH +: WIDTH] = din & {WIDTH{ch_en[i]}};
      end
   end

   // Channel registers. An asynchronous reset clears every channel immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else begin
         dout <= dout_d;
      end
   end

endmodule : demux_1to4

// File: tb/tb_demux_1to4.sv
// Directed bench for demux_1to4. It drives a WIDTH=1 and a WIDTH=8 instance in lockstep.
module tb_demux_1to4;
   import demux_1to4_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   logic [31:0] exp_q[$];

   demux_1to4_if #(.WIDTH(1)) if1 ();
   demux_1to4_if #(.WIDTH(8)) if8 ();

   demux_1to4 #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (if1.din),
      .sel   (if1.sel),
      .dout  (if1.dout)
   );

   demux_1to4 #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (if8.din),
      .sel   (if8.sel),
      .dout  (if8.dout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver: put values on both instances
   task automatic drive(input logic d1, input logic [7:0] d8, input sel_t s);
      if1.din = d1;
      if1.sel = s;
      if8.din = d8;
      if8.sel = s;
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // directed WIDTH=8 vectors: din, sel, expected dout
   logic [7:0]  v_din  [6] = '{8'hA5, 8'hA5, 8'hFF, 8'h3C, 8'h81, 8'h00};
   sel_t        v_sel  [6] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b01};
   logic [31:0] v_exp  [6] = '{32'h00A5_0000, 32'h0000_00A5, 32'hFF00_0000,
                               32'h0000_3C00, 32'h0081_0000, 32'h0000_0000};

   logic [31:0] exp_v;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      drive(1'b1, 8'h5A, 2'b01);

      // reset held while clocking
      repeat (3) tick();
      check("rst_hold_w1", {28'd0, if1.dout}, 32'h0);
      check("rst_hold_w8", if8.dout, 32'h0);

      // release mid-cycle: nothing changes until the next edge
      #2 rst_n = 1'b1;
      #1;
      check("rst_release_w1", {28'd0, if1.dout}, 32'h0);
      check("rst_release_w8", if8.dout, 32'h0);
      tick();
      check("first_edge_w1", {28'd0, if1.dout}, 32'h2);
      check("first_edge_w8", if8.dout, 32'h0000_5A00);

      // walk sel across all channels with din=1 and check one-cycle latency
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'hC3, sel_t'(i));
         exp_q.push_back(32'h1 << i);
         #2;
         if (i > 0) check("latency_hold", {28'd0, if1.dout}, 32'h1 << (i - 1));
         tick();
         exp_v = exp_q.pop_front();
         check("walk_w1", {28'd0, if1.dout}, exp_v);
      end
      check("walk_w8_last", if8.dout, 32'hC300_0000);

      // din=0 clears everything
      drive(1'b0, 8'h00, 2'b10);
      tick();
      check("din_zero_w1", {28'd0, if1.dout}, 32'h0);
      check("din_zero_w8", if8.dout, 32'h0);

      // asynchronous reset pulse between edges
      drive(1'b1, 8'h77, 2'b11);
      tick();
      check("pre_pulse_w1", {28'd0, if1.dout}, 32'h8);
      check("pre_pulse_w8", if8.dout, 32'h7700_0000);
      #1 rst_n = 1'b0;
      #1;
      check("async_clear_w1", {28'd0, if1.dout}, 32'h0);
      check("async_clear_w8", if8.dout, 32'h0);
      #1 rst_n = 1'b1;
      #1;
      check("after_pulse_w1", {28'd0, if1.dout}, 32'h0);

      // sel glitches between edges: only the value at the edge counts
      tick();
      check("resume_w1", {28'd0, if1.dout}, 32'h8);
      drive(1'b1, 8'h11, 2'b00);
      #1 drive(1'b1, 8'h11, 2'b11);
      #1 drive(1'b1, 8'h11, 2'b00);
      #1;
      check("glitch_hold_w1", {28'd0, if1.dout}, 32'h8);
      tick();
      check("glitch_00_w1", {28'd0, if1.dout}, 32'h1);
      check("glitch_00_w8", if8.dout, 32'h0000_0011);
      drive(1'b1, 8'h22, 2'b00);
      #1 drive(1'b1, 8'h22, 2'b11);
      tick();
      check("glitch_11_w1", {28'd0, if1.dout}, 32'h8);
      check("glitch_11_w8", if8.dout, 32'h2200_0000);

      // WIDTH=8 directed table; data passes unmodified and no channel keeps stale data
      for (int i = 0; i < 6; i++) begin
         drive(v_din[i][0], v_din[i], v_sel[i]);
         tick();
         check("w8_table", if8.dout, v_exp[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_demux_1to4
